// File: rtl/alarm_ringer.sv
// Alarm responder: converts the comparator's match level into buzzer drive with snooze/dismiss.
// Optional ALARM_BEEP_PATTERN_EN gates the buzzer 1 s on / 1 s off while ringing.
module alarm_ringer #(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic       alarm_in,
  input  logic       snooze,
  input  logic       dismiss,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozed,
  output logic [2:0] snooze_count
);

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;

  localparam logic [9:0] RING_LOAD   = 10'(RING_SEC);
  localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_SEC);
  localparam logic [2:0] MAX_CNT     = 3'(MAX_SNOOZE);

  state_t     r_state, w_state_nxt;
  logic [9:0] r_timer, w_timer_nxt;
  logic [2:0] r_count, w_count_nxt;
  logic       r_alarm_q;
  logic       r_buzzer, r_ringing, r_snoozed;
  logic       w_trig, w_can_snooze, w_last_sec, w_buzzer_nxt;

  assign w_trig       = alarm_in & ~r_alarm_q;
  assign w_can_snooze = (r_count < MAX_CNT);
  assign w_last_sec   = (r_timer == 10'd1);

  // Priority inside each state: dismiss > snooze > trig > tick timeout.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_count_nxt = r_count;
    unique case (r_state)
      IDLE: begin
        if (w_trig) begin
          w_state_nxt = RINGING;
          w_timer_nxt = RING_LOAD;
          w_count_nxt = '0;
        end
      end
      RINGING: begin
        if (dismiss) begin
          w_state_nxt = IDLE;
          w_count_nxt = '0;
        end else if (snooze && w_can_snooze) begin
          w_state_nxt = SNOOZE;
          w_timer_nxt = SNOOZE_LOAD;
          w_count_nxt = r_count + 3'd1;
        end else if (sec_tick) begin
          w_timer_nxt = r_timer - 10'd1;
          if (w_last_sec) begin
            w_state_nxt = IDLE;
            w_count_nxt = '0;
          end
        end
      end
      SNOOZE: begin
        if (dismiss) begin
          w_state_nxt = IDLE;
          w_count_nxt = '0;
        end else if (w_trig) begin
          w_state_nxt = RINGING;
          w_timer_nxt = RING_LOAD;
        end else if (sec_tick) begin
          if (w_last_sec) begin
            w_state_nxt = RINGING;
            w_timer_nxt = RING_LOAD;
          end else begin
            w_timer_nxt = r_timer - 10'd1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

`ifdef ALARM_BEEP_PATTERN_EN
  logic r_phase, w_phase_nxt;

  always_comb begin
    w_phase_nxt = r_phase;
    if (w_state_nxt == RINGING && r_state != RINGING) w_phase_nxt = 1'b0;
    else if (r_state == RINGING && sec_tick)          w_phase_nxt = ~r_phase;
  end

  assign w_buzzer_nxt = (w_state_nxt == RINGING) & ~w_phase_nxt;

  always_ff @(posedge clk) begin
    if (reset) r_phase <= 1'b0;
    else       r_phase <= w_phase_nxt;
  end
`else
  assign w_buzzer_nxt = (w_state_nxt == RINGING);
`endif

  // Outputs are registered from the next state so they line up with the state flop.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (reset) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      r_count   <= '0;
      r_alarm_q <= 1'b0;
      r_buzzer  <= 1'b0;
      r_ringing <= 1'b0;
      r_snoozed <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_count   <= w_count_nxt;
      r_alarm_q <= alarm_in;
      r_buzzer  <= w_buzzer_nxt;
      r_ringing <= (w_state_nxt == RINGING);
      r_snoozed <= (w_state_nxt == SNOOZE);
    end
  end

  assign buzzer       = r_buzzer;
  assign ringing      = r_ringing;
  assign snoozed      = r_snoozed;
  assign snooze_count = r_count;

endmodule

// File: tb/tb_alarm_ringer.sv
// Scoreboard bench for alarm_ringer: stimulus queues expected outputs, a monitor checks them.
module tb_alarm_ringer;

  localparam int RING_SEC   = 5;
  localparam int SNOOZE_SEC = 4;
  localparam int MAX_SNOOZE = 2;
`ifdef ALARM_BEEP_PATTERN_EN
  localparam bit BEEP = 1'b1;
`else
  localparam bit BEEP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sec_tick = 1'b0, alarm_in = 1'b0, snooze = 1'b0, dismiss = 1'b0;
  logic       buzzer, ringing, snoozed;
  logic [2:0] snooze_count;

  typedef struct {
    string      name;
    logic [5:0] val;  // {ringing, snoozed, buzzer, snooze_count}
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  alarm_ringer #(.RING_SEC(RING_SEC), .SNOOZE_SEC(SNOOZE_SEC), .MAX_SNOOZE(MAX_SNOOZE)) dut (
    .clk(clk), .reset(reset), .sec_tick(sec_tick), .alarm_in(alarm_in),
    .snooze(snooze), .dismiss(dismiss), .buzzer(buzzer), .ringing(ringing),
    .snoozed(snoozed), .snooze_count(snooze_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got r/s/b/cnt=%b/%b/%b/%0d, expected %b/%b/%b/%0d",
               name, act[5], act[4], act[3], act[2:0], req[5], req[4], req[3], req[2:0]);
    end
  endtask

  // Drive one clock of inputs; pulses drop just after the sampling edge.
  task automatic cyc(input logic t, input logic s, input logic d);
    sec_tick = t; snooze = s; dismiss = d;
    @(posedge clk);
    #1;
    sec_tick = 1'b0; snooze = 1'b0; dismiss = 1'b0;
  endtask

  task automatic ex(input string name, input logic r, input logic sz, input logic b,
                    input int c);
    exp_t e;
    e.name = name;
    e.val  = {r, sz, b, 3'(c)};
    q.push_back(e);
  endtask

  // Expected buzzer k ticks after entering RINGING.
  function automatic logic bz(input int k);
    return BEEP ? logic'(k % 2 == 0) : 1'b1;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check(e.name, {ringing, snoozed, buzzer, snooze_count}, e.val);
      end
    end
  end

  initial begin : stimulus
    cyc(0, 0, 0);
    ex("reset", 0, 0, 0, 0);
    reset = 1'b0;
    cyc(0, 0, 0);
    ex("idle", 0, 0, 0, 0);

    // Long alarm level triggers once; auto-stop on the RING_SEC-th tick.
    alarm_in = 1'b1;
    cyc(0, 0, 0); ex("trig", 1, 0, 1, 0);
    for (int k = 1; k <= 3; k++) begin
      cyc(1, 0, 0); ex("ring_tick", 1, 0, bz(k), 0);
    end
    alarm_in = 1'b0;
    cyc(1, 0, 0); ex("ring_tick4", 1, 0, bz(4), 0);
    cyc(1, 0, 0); ex("auto_stop", 0, 0, 0, 0);
    cyc(0, 0, 0); ex("stay_idle", 0, 0, 0, 0);

    // Snooze, resume with reloaded timer, exhaust snoozes, dismiss.
    alarm_in = 1'b1;
    cyc(0, 0, 0); ex("trig2", 1, 0, 1, 0);
    alarm_in = 1'b0;
    cyc(0, 1, 0); ex("snooze1", 0, 1, 0, 1);
    for (int k = 1; k <= 3; k++) begin
      cyc(1, 0, 0); ex("snoozing", 0, 1, 0, 1);
    end
    cyc(1, 0, 0); ex("resume1", 1, 0, 1, 1);
    for (int k = 1; k <= 4; k++) begin
      cyc(1, 0, 0); ex("reloaded", 1, 0, bz(k), 1);
    end
    cyc(0, 1, 0); ex("snooze2", 0, 1, 0, 2);
    for (int k = 1; k <= 3; k++) begin
      cyc(1, 0, 0); ex("snoozing2", 0, 1, 0, 2);
    end
    cyc(1, 0, 0); ex("resume2", 1, 0, 1, 2);
    cyc(0, 1, 0); ex("snooze_max", 1, 0, 1, 2);
    for (int k = 1; k <= 4; k++) begin
      cyc(1, 0, 0); ex("timer_kept", 1, 0, bz(k), 2);
    end
    cyc(0, 0, 1); ex("dismiss", 0, 0, 0, 0);
    cyc(0, 1, 0); ex("idle_snooze", 0, 0, 0, 0);
    cyc(0, 0, 1); ex("idle_dismiss", 0, 0, 0, 0);

    // Snooze and dismiss together: dismiss wins.
    alarm_in = 1'b1;
    cyc(0, 0, 0); ex("trig3", 1, 0, 1, 0);
    alarm_in = 1'b0;
    cyc(0, 1, 1); ex("snz_and_dis", 0, 0, 0, 0);

    // Reset during SNOOZE with timer=3; no resume afterwards.
    alarm_in = 1'b1;
    cyc(0, 0, 0); ex("trig4", 1, 0, 1, 0);
    alarm_in = 1'b0;
    cyc(0, 1, 0); ex("snooze_r", 0, 1, 0, 1);
    cyc(1, 0, 0); ex("snooze_t3", 0, 1, 0, 1);
    reset = 1'b1;
    cyc(0, 0, 0); ex("reset_snz", 0, 0, 0, 0);
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cyc(1, 0, 0); ex("post_reset", 0, 0, 0, 0);
    end

    // Snooze on the final tick beats auto-stop; trig in SNOOZE keeps the count.
    alarm_in = 1'b1;
    cyc(0, 0, 0); ex("trig5", 1, 0, 1, 0);
    alarm_in = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cyc(1, 0, 0); ex("ring5", 1, 0, bz(k), 0);
    end
    cyc(1, 1, 0); ex("snz_final", 0, 1, 0, 1);
    cyc(0, 0, 0); ex("snz_hold", 0, 1, 0, 1);
    alarm_in = 1'b1;
    cyc(0, 0, 0); ex("snz_trig", 1, 0, 1, 1);
    alarm_in = 1'b0;
    cyc(0, 0, 1); ex("dismiss2", 0, 0, 0, 0);

    repeat (4) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
